// File: rtl/fifo_pkg.sv
// Shared constants and beat type for the read-side FIFO packer.
package fifo_pkg;

   localparam int FIFO_DATA_W   = 8;
   localparam int PACK_RATIO    = 4;
   localparam int FLUSH_TIMEOUT = 16;
   localparam int PACK_OUT_W    = FIFO_DATA_W * PACK_RATIO;

   typedef struct packed {
      logic [PACK_OUT_W-1:0] data;
      logic [PACK_RATIO-1:0] keep;
      logic                  last;
   } beat_t;

endpackage

// File: rtl/fifo_flush_timer.sv
// Idle timer and flush-pending flag for the packer's partial word.
module fifo_flush_timer
   import fifo_pkg::*;
#(
   parameter int TIMEOUT = FLUSH_TIMEOUT
) (
   input  logic rd_clk,
   input  logic rd_rst,
   input  logic partial,
   input  logic nonempty,
   input  logic pop,
   input  logic xfer,
   input  logic flush_req,
   output logic flush_pend
);

   localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [IDLE_W-1:0] idle_cnt;
   logic              idle_tick;
   logic              timeout_hit;

   assign idle_tick = partial & !pop & !flush_pend;

   generate
      if (TIMEOUT > 0) begin : g_timeout
         assign timeout_hit = idle_tick & (idle_cnt == IDLE_W'(TIMEOUT - 1));
      end else begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end
   endgenerate

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) begin
         idle_cnt <= '0;
      end else if (idle_tick && !timeout_hit) begin
         idle_cnt <= idle_cnt + 1'b1;
      end else begin
         idle_cnt <= '0;
      end
   end

   // A flush arriving while a word leaves is folded into that word's last flag.
   always_ff @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) begin
         flush_pend <= 1'b0;
      end else if (xfer) begin
         flush_pend <= 1'b0;
      end else if ((flush_req && nonempty) || timeout_hit) begin
         flush_pend <= 1'b1;
      end
   end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops bytes from the async FIFO read port and packs them little-endian into output words.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int IN_W    = FIFO_DATA_W,
   parameter int RATIO   = PACK_RATIO,
   parameter int TIMEOUT = FLUSH_TIMEOUT
) (
   input  logic                 rd_clk,
   input  logic                 rd_rst,
   input  logic                 fifo_empty,
   input  logic [IN_W-1:0]      fifo_rd_data,
   output logic                 fifo_rd_en,
   input  logic                 flush_req,
   output logic [IN_W*RATIO-1:0] out_data,
   output logic [RATIO-1:0]     out_keep,
   output logic                 out_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [15:0]          word_cnt
);

   localparam int OUT_W = IN_W * RATIO;
   localparam int CNT_W = $clog2(RATIO + 1);

   logic [OUT_W-1:0] asm_data;
   logic [CNT_W-1:0] asm_cnt;
   logic [CNT_W-1:0] lane;
   logic [RATIO-1:0] asm_keep;
   logic             flush_pend;
   logic             asm_full;
   logic             asm_nonempty;
   logic             out_free;
   logic             xfer;
   logic             pop;

   assign asm_full     = (asm_cnt == CNT_W'(RATIO));
   assign asm_nonempty = (asm_cnt != '0);
   assign out_free     = !out_valid | out_ready;
   assign xfer         = out_free & (asm_full | (flush_pend & asm_nonempty));
   assign pop          = !fifo_empty & (xfer | (!asm_full & !flush_pend));
   assign fifo_rd_en   = pop;
   assign lane         = xfer ? '0 : asm_cnt;

   // NOTE: combinational outputs get a default before any conditional write, so no latch is inferred.
   always_comb begin
      asm_keep = '0;
      for (int i = 0; i < RATIO; i++) begin
         asm_keep[i] = (CNT_W'(i) < asm_cnt);
      end
   end

   fifo_flush_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_flush_timer (
      .rd_clk     (rd_clk),
      .rd_rst     (rd_rst),
      .partial    (asm_nonempty & !asm_full),
      .nonempty   (asm_nonempty),
      .pop        (pop),
      .xfer       (xfer),
      .flush_req  (flush_req),
      .flush_pend (flush_pend)
   );

   // NOTE: asm_data is reset and cleared on every transfer because unused lanes of a partial word must read 0.
   always_ff @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) begin
         asm_data <= '0;
         asm_cnt  <= '0;
      end else begin
         if (xfer) begin
            asm_data <= '0;
            asm_cnt  <= pop ? CNT_W'(1) : '0;
         end else if (pop) begin
            asm_cnt <= asm_cnt + 1'b1;
         end
         // Lane write comes after the clear so a byte popped during xfer survives in lane 0.
         for (int i = 0; i < RATIO; i++) begin
            if (pop && (lane == CNT_W'(i))) begin
               asm_data[i*IN_W +: IN_W] <= fifo_rd_data;
            end
         end
      end
   end

   always_ff @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) begin
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
         word_cnt  <= '0;
      end else begin
         if (xfer) begin
            out_data  <= asm_data;
            out_keep  <= asm_keep;
            out_last  <= flush_pend | flush_req;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (out_valid && out_ready) begin
            word_cnt <= word_cnt + 1'b1;
         end
      end
   end

endmodule
